// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice blocks.
//   adsr_state_e : envelope phase encoding, also driven out on adsr_envelope.state
//   env_max()    : full-scale envelope level (2^width - 1) for a given level width
//   ENV_MAX      : full-scale level for the default 16-bit envelope
package synth_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAttack  = 3'd1,
    StDecay   = 3'd2,
    StSustain = 3'd3,
    StRelease = 3'd4
  } adsr_state_e;

  localparam int unsigned ENV_WIDTH_DEFAULT = 16;

  function automatic logic [31:0] env_max(int unsigned width);
    return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
  endfunction

  localparam logic [ENV_WIDTH_DEFAULT-1:0] ENV_MAX = 16'(env_max(ENV_WIDTH_DEFAULT));

endpackage

// File: rtl/env_multiplier.sv
// Two-stage signed sample x envelope scaler.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   valid_i       : sample strobe; din_i and env_i are captured on this cycle
//   din_i         : signed audio sample
//   env_i         : unsigned envelope level
//   dout_o        : (din_i * env_i) >>> EnvWidth, updated two clocks after valid_i
//   valid_o       : one-clock pulse coinciding with each dout_o update
module env_multiplier #(
  parameter int unsigned DataWidth = 24,
  parameter int unsigned EnvWidth  = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        valid_i,
  input  logic signed [DataWidth-1:0] din_i,
  input  logic        [EnvWidth-1:0]  env_i,
  output logic signed [DataWidth-1:0] dout_o,
  output logic                        valid_o
);

  localparam int unsigned ProdWidth = DataWidth + EnvWidth + 1;

  logic signed [ProdWidth-1:0] din_ext, env_ext, prod_d, prod_q;
  logic signed [DataWidth-1:0] dout_d, dout_q;
  logic                        valid1_q, valid2_q;
  logic                        unused_prod_msb;

  // env is zero-extended so it always acts as a non-negative multiplicand.
  assign din_ext = ProdWidth'(din_i);
  assign env_ext = $signed(ProdWidth'({1'b0, env_i}));

  always_comb begin
    prod_d = prod_q;
    if (valid_i) begin
      prod_d = din_ext * env_ext;
    end
  end

  // |din * env| < 2^(DataWidth+EnvWidth-1), so the top product bit is pure sign
  // extension and this slice is exactly the floor arithmetic shift.
  always_comb begin
    dout_d = dout_q;
    if (valid1_q) begin
      dout_d = $signed(prod_q[EnvWidth +: DataWidth]);
    end
  end

  assign unused_prod_msb = prod_q[ProdWidth-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_q   <= '0;
      valid1_q <= 1'b0;
      dout_q   <= '0;
      valid2_q <= 1'b0;
    end else begin
      prod_q   <= prod_d;
      valid1_q <= valid_i;
      dout_q   <= dout_d;
      valid2_q <= valid1_q;
    end
  end

  assign dout_o  = dout_q;
  assign valid_o = valid2_q;

endmodule

// File: rtl/adsr_envelope.sv
// ADSR envelope generator with sample scaling.
//   clk, reset            : clock, asynchronous active-low reset
//   sample_en             : one-clock strobe per audio sample; env steps only here
//   gate                  : note on/off, edges detected against last clock's value
//   attack/decay/release_rate : per-sample level step (0 = jump to target)
//   sustain_level         : decay target, tracked live while sustaining
//   din                   : signed oscillator sample, used on sample_en
//   dout, dout_valid      : enveloped sample and its update pulse (2 clocks latency)
//   env, state            : current level and phase
module adsr_envelope
  import synth_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned ENV_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sample_en,
  input  logic                         gate,
  input  logic        [ENV_WIDTH-1:0]  attack_rate,
  input  logic        [ENV_WIDTH-1:0]  decay_rate,
  input  logic        [ENV_WIDTH-1:0]  release_rate,
  input  logic        [ENV_WIDTH-1:0]  sustain_level,
  input  logic signed [DATA_WIDTH-1:0] din,
  output logic signed [DATA_WIDTH-1:0] dout,
  output logic                         dout_valid,
  output logic        [ENV_WIDTH-1:0]  env,
  output logic        [2:0]            state
);

  localparam logic [ENV_WIDTH-1:0] EnvMax = ENV_WIDTH'(env_max(ENV_WIDTH));

  adsr_state_e          state_d, state_q;
  logic [ENV_WIDTH-1:0] env_d, env_q;
  logic                 gate_q;
  logic                 gate_rise, gate_fall;
  logic [ENV_WIDTH:0]   attack_sum;
  logic                 decay_done;

  assign gate_rise = gate & ~gate_q;
  assign gate_fall = ~gate & gate_q;

  assign attack_sum = {1'b0, env_q} + {1'b0, attack_rate};
  // env - rate <= sustain, evaluated without underflow.
  assign decay_done = (decay_rate == '0) ||
                      ({1'b0, env_q} <= ({1'b0, decay_rate} + {1'b0, sustain_level}));

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    // Gate edges win over a coincident sample step; env is left untouched so a
    // retrigger starts climbing from the current level without a click.
    if (gate_rise) begin
      state_d = StAttack;
    end else if (gate_fall &&
                 (state_q inside {StAttack, StDecay, StSustain})) begin
      state_d = StRelease;
    end else if (sample_en) begin
      case (state_q)
        StIdle: begin
          env_d = '0;
        end
        StAttack: begin
          if ((attack_rate == '0) || (attack_sum >= {1'b0, EnvMax})) begin
            env_d   = EnvMax;
            state_d = StDecay;
          end else begin
            env_d = attack_sum[ENV_WIDTH-1:0];
          end
        end
        StDecay: begin
          if (decay_done) begin
            env_d   = sustain_level;
            state_d = StSustain;
          end else begin
            env_d = env_q - decay_rate;
          end
        end
        StSustain: begin
          env_d = sustain_level;
        end
        StRelease: begin
          if ((release_rate == '0) || (env_q <= release_rate)) begin
            env_d   = '0;
            state_d = StIdle;
          end else begin
            env_d = env_q - release_rate;
          end
        end
        default: begin
          env_d   = '0;
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      env_q   <= '0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      gate_q  <= gate;
    end
  end

  // Scales by the level held during the sample_en cycle, before this step lands.
  env_multiplier #(
    .DataWidth(DATA_WIDTH),
    .EnvWidth (ENV_WIDTH)
  ) u_env_multiplier (
    .clk_i  (clk),
    .rst_ni (reset),
    .valid_i(sample_en),
    .din_i  (din),
    .env_i  (env_q),
    .dout_o (dout),
    .valid_o(dout_valid)
  );

  assign env   = env_q;
  assign state = state_q;

endmodule

// File: doc/adsr_envelope.md
ADSR_ENVELOPE -- requirements
Module: adsr_envelope

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, meaning signed audio sample width of din/dout.
REQ-002 SHALL have parameter ENV_WIDTH, default 16, meaning unsigned envelope level/rate width; full scale ENV_MAX = 2^ENV_WIDTH-1.
REQ-003 SHALL have port clk  input  1  the single clock (main_clk domain); all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sample_en  input  1  one-clk strobe per audio sample.
REQ-006 SHALL have port gate  input  1  note on (1) / off (0), level-sensitive, synchronous to clk.
REQ-007 SHALL have ports attack_rate, decay_rate, release_rate  input  ENV_WIDTH each  per-sample level step; 0 = instantaneous.
REQ-008 SHALL have port sustain_level  input  ENV_WIDTH  decay target level.
REQ-009 SHALL have port din  input  DATA_WIDTH  signed oscillator sample, sampled when sample_en=1.
REQ-010 SHALL have port dout  output  DATA_WIDTH  signed enveloped sample, to filter/DAC.
REQ-011 SHALL have port dout_valid  output  1  one-clk pulse when dout updates.
REQ-012 SHALL have port env  output  ENV_WIDTH  current envelope level.
REQ-013 SHALL have port state  output  3  current phase encoding.

Function
REQ-014 SHALL implement states IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
REQ-015 SHALL register gate every clk; rising edge (gate=1, prev=0) SHALL force ATTACK next clk from any state, env unchanged (retrigger, no click).
REQ-016 SHALL on falling edge force RELEASE from ATTACK/DECAY/SUSTAIN next clk; falling edge in IDLE/RELEASE no effect.
REQ-017 SHALL change env only on sample_en cycles; gate edge coinciding with sample_en SHALL take priority: state changes, no env step that cycle.
REQ-018 ATTACK on sample_en: env = min(env+attack_rate, ENV_MAX), sum computed ENV_WIDTH+1 bits; on reaching ENV_MAX go DECAY; attack_rate=0 sets ENV_MAX immediately.
REQ-019 DECAY on sample_en: env = max(env-decay_rate, sustain_level), no underflow; on reaching sustain_level go SUSTAIN; decay_rate=0 jumps to sustain_level; env<=sustain_level at entry jumps likewise.
REQ-020 SUSTAIN on sample_en: env = sustain_level (tracks live changes).
REQ-021 RELEASE on sample_en: env = max(env-release_rate, 0); on reaching 0 go IDLE; release_rate=0 jumps to 0.
REQ-022 IDLE: env held at 0; dout still produced (0) every sample_en.
REQ-023 SHALL compute dout = (din * {0,env}) >>> ENV_WIDTH, full-precision signed product (DATA_WIDTH+ENV_WIDTH+1 bits), arithmetic shift (floor), no saturation needed.
REQ-024 Product SHALL use din and env values present in the sample_en cycle (pre-update env).
REQ-025 Latency: dout and dout_valid update exactly 2 clks after sample_en; dout holds between updates.
REQ-026 Back-to-back sample_en (every clk) SHALL be supported at full throughput.

Reset
REQ-027 reset=0 SHALL asynchronously set state IDLE, env 0, dout 0, dout_valid 0, gate history 0, pipeline regs 0.
REQ-028 Reset release mid-note: with gate=1 held, first clk after release SHALL detect rising edge and enter ATTACK from 0.

Structure
REQ-029 State encodings and ENV_MAX SHALL live in shared package synth_pkg.
REQ-030 The 2-stage signed multiply/shift SHALL be sub-module env_multiplier; state machine and level arithmetic in adsr_envelope.

Verification
REQ-031 Reset asserted mid-ATTACK (env=0x8000) -> env=0, state=IDLE, dout=0, dout_valid=0 without clk edge.
REQ-032 attack_rate=0x4000, gate rise, 4 sample_en -> env 0x4000, 0x8000, 0xC000, 0xFFFF, then state DECAY.
REQ-033 decay_rate=0x4000, sustain=0x8000 from 0xFFFF -> env 0xBFFF, 0x8000, state SUSTAIN; din=0x400000 -> dout=0x200000 2 clks after sample_en.
REQ-034 gate fall at env=0x8000 in ATTACK, release_rate=0x3000 -> env 0x5000, 0x2000, 0x0000, state IDLE.
REQ-035 attack_rate=0, din=0xC00000 (-0x400000) -> env 0xFFFF on first sample; next sample dout=0xC00040.
REQ-036 gate re-rise in RELEASE at env=0x5000 coincident with sample_en -> state ATTACK, env stays 0x5000 that cycle, climbs on next sample_en.
